gpio_cmd_master: RTL

//  Micro-side initiator of the 32-bit GPIO register-file protocol: word[31:24]=address, [23]=write strobe, [22:0]=data.

---
 rtl/gpio_cmd_master.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/gpio_cmd_master.sv
// Initiator for the 32-bit GPIO register-file protocol. It turns valid/ready
// write and read commands into strobed GPIO words using setup, strobe and clear phases.
module gpio_cmd_master #(
    parameter int unsigned NB_GPIOS        = 32,
    parameter int unsigned NB_GPIO_DATA    = 23,
    parameter int unsigned NB_GPIO_ADDRESS = 8,
    parameter int unsigned NB_HOLD         = 4
) (
    input  logic                       clock,
    input  logic                       in_reset_n,
    input  logic                       in_cmd_valid,
    output logic                       out_cmd_ready,
    input  logic                       in_cmd_write,
    input  logic [NB_GPIO_ADDRESS-1:0] in_cmd_addr,
    input  logic [NB_GPIO_DATA-1:0]    in_cmd_data,
    input  logic [NB_HOLD-1:0]         in_hold_cycles,
    output logic [NB_GPIOS-1:0]        out_micro_to_rf_data,
    input  logic [NB_GPIOS-1:0]        in_rf_to_micro_data,
    output logic                       out_rsp_valid,
    output logic [NB_GPIOS-1:0]        out_rsp_data,
    input  logic                       in_rsp_ready,
    output logic                       out_busy
);
    // One extra counter bit so that the WAIT phase (H+3 cycles) fits.
    localparam int unsigned NbCnt = NB_HOLD + 1;
    localparam int unsigned NbPad = NB_GPIO_DATA - NB_GPIO_ADDRESS;

    typedef enum logic [2:0] {StIdle, StSetup, StStrobe, StClear, StWait, StSample} state_e;

    state_e                     state_q, state_d;
    logic [NbCnt-1:0]           cnt_q, cnt_d;
    logic [NB_HOLD-1:0]         hold_q, hold_d;
    logic                       write_q, write_d;
    logic [NB_GPIO_ADDRESS-1:0] addr_q, addr_d;
    logic [NB_GPIO_DATA-1:0]    data_q, data_d;
    logic                       rsp_valid_q, rsp_valid_d;
    logic [NB_GPIOS-1:0]        rsp_data_q, rsp_data_d;

    logic               accept;
    logic               cnt_done;
    logic               strobe_en;
    logic [NB_HOLD-1:0] hold_eff;
    logic [NbCnt-1:0]   phase_load;

    assign out_cmd_ready = in_reset_n && (state_q == StIdle) && !rsp_valid_q;
    assign accept        = in_cmd_valid && out_cmd_ready;
    assign hold_eff      = (in_hold_cycles == '0) ? NB_HOLD'(1) : in_hold_cycles;
    assign cnt_done      = (cnt_q == '0);
    assign phase_load    = NbCnt'(hold_q) - NbCnt'(1);
    assign strobe_en     = (state_q == StStrobe);
    assign out_busy      = (state_q != StIdle);
    assign out_rsp_valid = rsp_valid_q;
    assign out_rsp_data  = rsp_data_q;

    // A read selects register 0 by writing the target address into its low bits.
    assign out_micro_to_rf_data = write_q ? {addr_q, strobe_en, data_q}
                                          : {{NB_GPIO_ADDRESS{1'b0}}, strobe_en, {NbPad{1'b0}}, addr_q};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        write_d     = write_q;
        addr_d      = addr_q;
        data_d      = data_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;

        if (rsp_valid_q && in_rsp_ready) begin
            rsp_valid_d = 1'b0;
        end

        case (state_q)
            StIdle: begin
                if (accept) begin
                    write_d = in_cmd_write;
                    addr_d  = in_cmd_addr;
                    data_d  = in_cmd_data;
                    hold_d  = hold_eff;
                    cnt_d   = NbCnt'(hold_eff) - NbCnt'(1);
                    state_d = StSetup;
                end
            end
            StSetup: begin
                if (cnt_done) begin
                    cnt_d   = phase_load;
                    state_d = StStrobe;
                end else begin
                    cnt_d = cnt_q - NbCnt'(1);
                end
            end
            StStrobe: begin
                if (cnt_done) begin
                    cnt_d   = phase_load;
                    state_d = StClear;
                end else begin
                    cnt_d = cnt_q - NbCnt'(1);
                end
            end
            StClear: begin
                if (cnt_done) begin
                    if (write_q) begin
                        cnt_d   = '0;
                        state_d = StIdle;
                    end else begin
                        cnt_d   = NbCnt'(hold_q) + NbCnt'(2);
                        state_d = StWait;
                    end
                end else begin
                    cnt_d = cnt_q - NbCnt'(1);
                end
            end
            StWait: begin
                if (cnt_done) begin
                    state_d = StSample;
                end else begin
                    cnt_d = cnt_q - NbCnt'(1);
                end
            end
            StSample: begin
                rsp_data_d  = in_rf_to_micro_data;
                rsp_valid_d = 1'b1;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!in_reset_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            hold_q      <= '0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

endmodule
